// File: rtl/qpsk_pkg.sv
// Shared types and helpers for the QPSK symbol mapper: quadrant index, FSM states,
// the Gray dibit-to-quadrant map and the default constellation magnitude.
package qpsk_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int AMP_DEFAULT = 23170;

  // Dibits 00,01,11,10 walk the quadrants 0..3 so adjacent symbols differ by one bit.
  function automatic quad_t gray_to_quad(input logic [1:0] dibit);
    quad_t q;
    case (dibit)
      2'b00:   q = 2'd0;
      2'b01:   q = 2'd1;
      2'b11:   q = 2'd2;
      2'b10:   q = 2'd3;
      default: q = 2'd0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/qpsk_rate_gen.sv
// Symbol-rate divider: one tick every rate_div+1 cycles while running.
module qpsk_rate_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = run && (cnt_r == {DIV_W{1'b0}});

  // Down-counter; rate_div is only looked at on start and on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (start) begin
      cnt_r <= rate_div;
    end else if (run) begin
      if (cnt_r == {DIV_W{1'b0}}) begin
        cnt_r <= rate_div;
      end else begin
        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= {DIV_W{1'b0}};
    end
  end

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// QPSK mapper: streams 32-bit words out as 16 Gray-coded I/Q symbols, MSB dibit first.
// Define QPSK_DIFF_ENC_EN to make the quadrant index accumulate (differential encoding).
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int IQ_W  = 16,
  parameter int DIV_W = 16,
  parameter int AMP   = AMP_DEFAULT
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic signed [IQ_W-1:0] i_out,
  output logic signed [IQ_W-1:0] q_out,
  output logic                   sym_valid,
  output logic                   underrun,
  output logic                   busy
);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] RUN  = ST_RUN;
  localparam logic signed [IQ_W-1:0] POS_A = IQ_W'(AMP);
  localparam logic signed [IQ_W-1:0] NEG_A = -POS_A;
  localparam logic signed [IQ_W-1:0] ZERO  = {IQ_W{1'b0}};

  logic [0:0]            state_r;
  logic                  run_s;
  logic                  start_s;
  logic                  tick_s;
  logic                  last_s;
  logic                  accept_s;
  logic [31:0]           shreg_r;
  logic [3:0]            cnt4_r;
  logic                  full_r;
  quad_t                 gray_s;
  quad_t                 quad_s;
  logic signed [IQ_W-1:0] map_i_s;
  logic signed [IQ_W-1:0] map_q_s;

  // run_s drops in the same cycle enable falls, so an abort never emits a symbol.
  assign run_s    = (state_r == RUN) && enable;
  assign start_s  = (state_r == IDLE) && enable;
  assign last_s   = tick_s && full_r && (cnt4_r == 4'd15);
  assign s_ready  = run_s && (!full_r || last_s);
  assign accept_s = s_valid && s_ready;
  assign busy     = full_r;
  assign gray_s   = gray_to_quad(shreg_r[31:30]);

  qpsk_rate_gen #(.DIV_W(DIV_W)) u_rate_gen (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .start    (start_s),
    .run      (run_s),
    .rate_div (rate_div),
    .tick     (tick_s)
  );

`ifdef QPSK_DIFF_ENC_EN
  quad_t q_prev_r;

  assign quad_s = q_prev_r + gray_s;

  // Phase accumulator advances only on data symbols; underrun slots leave it alone.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      q_prev_r <= 2'd0;
    end else if (!run_s) begin
      q_prev_r <= 2'd0;
    end else if (tick_s && full_r) begin
      q_prev_r <= quad_s;
    end else begin
      q_prev_r <= q_prev_r;
    end
  end
`else
  assign quad_s = gray_s;
`endif

  // Quadrant index to constellation point.
  always_comb begin
    map_i_s = POS_A;
    map_q_s = POS_A;
    case (quad_s)
      2'd0:    begin map_i_s = POS_A; map_q_s = POS_A; end
      2'd1:    begin map_i_s = NEG_A; map_q_s = POS_A; end
      2'd2:    begin map_i_s = NEG_A; map_q_s = NEG_A; end
      2'd3:    begin map_i_s = POS_A; map_q_s = NEG_A; end
      default: begin map_i_s = POS_A; map_q_s = POS_A; end
    endcase
  end

  // Run-control FSM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= enable ? RUN : IDLE;
        RUN:     state_r <= enable ? RUN : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Word buffer; a word loaded on a tick is only consumed from the next tick onward.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      shreg_r <= 32'h0000_0000;
      cnt4_r  <= 4'd0;
      full_r  <= 1'b0;
    end else if (!run_s) begin
      shreg_r <= 32'h0000_0000;
      cnt4_r  <= 4'd0;
      full_r  <= 1'b0;
    end else if (accept_s) begin
      shreg_r <= s_data;
      cnt4_r  <= 4'd0;
      full_r  <= 1'b1;
    end else if (tick_s && full_r) begin
      shreg_r <= {shreg_r[29:0], 2'b00};
      cnt4_r  <= cnt4_r + 4'd1;
      full_r  <= (cnt4_r != 4'd15);
    end else begin
      shreg_r <= shreg_r;
      cnt4_r  <= cnt4_r;
      full_r  <= full_r;
    end
  end

  // Registered sample outputs, one cycle behind the tick.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      i_out     <= ZERO;
      q_out     <= ZERO;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (!run_s) begin
      i_out     <= ZERO;
      q_out     <= ZERO;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (tick_s) begin
      sym_valid <= 1'b1;
      underrun  <= !full_r;
      i_out     <= full_r ? map_i_s : ZERO;
      q_out     <= full_r ? map_q_s : ZERO;
    end else begin
      i_out     <= i_out;
      q_out     <= q_out;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Directed, table-driven bench for qpsk_symbol_mapper; expected samples are hand-computed.
module tb_qpsk_symbol_mapper;

  localparam logic [15:0] A  = 16'h5A82;
  localparam logic [15:0] NA = 16'hA57E;
  localparam logic [15:0] Z  = 16'h0000;

  logic               ACLK;
  logic               ARESETN;
  logic               enable;
  logic [15:0]        rate_div;
  logic [31:0]        s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               sym_valid;
  logic               underrun;
  logic               busy;

  qpsk_symbol_mapper #(.IQ_W(16), .DIV_W(16), .AMP(23170)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .rate_div(rate_div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .i_out(i_out),
    .q_out(q_out), .sym_valid(sym_valid), .underrun(underrun), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0]      word;
    logic [15:0]      rd;
    logic [0:3][15:0] ei;
    logic [0:3][15:0] eq;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [31:0] wq[$];
  int          s_cyc[$];
  logic [15:0] s_i[$];
  logic [15:0] s_q[$];
  bit          s_u[$];
  bit          s_b[$];
  int          d_cyc[$];
  logic [15:0] d_i[$];
  logic [15:0] d_q[$];
  bit          d_b[$];
  int n_und, n_undnz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr_log();
    s_cyc.delete(); s_i.delete(); s_q.delete(); s_u.delete(); s_b.delete();
    hs_cnt = 0;
  endtask

  // Drive the word queue with valid/ready and log every sym_valid strobe.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      logic acc;
      s_valid = (wq.size() != 0);
      s_data  = s_valid ? wq[0] : 32'h0;
      #1;
      acc = s_valid && s_ready;
      @(posedge ACLK);
      #1;
      if (acc) begin
        void'(wq.pop_front());
        hs_cnt++;
      end
      cyc++;
      if (sym_valid) begin
        s_cyc.push_back(cyc); s_i.push_back(i_out); s_q.push_back(q_out);
        s_u.push_back(underrun); s_b.push_back(busy);
      end
    end
  endtask

  task automatic split();
    d_cyc.delete(); d_i.delete(); d_q.delete(); d_b.delete();
    n_und = 0; n_undnz = 0;
    foreach (s_u[k]) begin
      if (!s_u[k]) begin
        d_cyc.push_back(s_cyc[k]); d_i.push_back(s_i[k]);
        d_q.push_back(s_q[k]); d_b.push_back(s_b[k]);
      end else begin
        n_und++;
        if (s_i[k] != Z || s_q[k] != Z) n_undnz++;
      end
    end
  endtask

  task automatic restart(input logic [15:0] rd);
    enable = 1'b0;
    wq.delete();
    run_cycles(2);
    clr_log();
    rate_div = rd;
    enable = 1'b1;
  endtask

  vec_t vecs[4];

  initial begin
    int bad;
    vecs[0] = '{word: 32'h1B1B1B1B, rd: 16'd3, ei: {A, NA, A, NA},   eq: {A, A, NA, NA}};
    vecs[1] = '{word: 32'hE4E4E4E4, rd: 16'd1, ei: {NA, A, NA, A},   eq: {NA, NA, A, A}};
    vecs[2] = '{word: 32'h2D000000, rd: 16'd2, ei: {A, A, NA, NA},   eq: {A, NA, NA, A}};
    vecs[3] = '{word: 32'hFFFFFFFF, rd: 16'd0, ei: {NA, NA, NA, NA}, eq: {NA, NA, NA, NA}};

    ARESETN = 1'b0; enable = 1'b1; rate_div = 16'd0; s_data = 32'hDEADBEEF; s_valid = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_i", i_out, Z);
    chk("rst_q", q_out, Z);
    chk("rst_sym_valid", sym_valid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    enable = 1'b0;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("idle_s_ready", s_ready, 1'b0);

`ifndef QPSK_DIFF_ENC_EN
    for (int v = 0; v < 4; v++) begin
      restart(vecs[v].rd);
      wq.push_back(vecs[v].word);
      run_cycles(17 * (int'(vecs[v].rd) + 1) + 6);
      split();
      chk($sformatf("vec%0d_count", v), d_i.size(), 16);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("vec%0d_i%0d", v, j), (j < d_i.size()) ? d_i[j] : 16'hxxxx, vecs[v].ei[j]);
        chk($sformatf("vec%0d_q%0d", v, j), (j < d_q.size()) ? d_q[j] : 16'hxxxx, vecs[v].eq[j]);
      end
      bad = 0;
      for (int j = 1; j < d_cyc.size(); j++)
        if (d_cyc[j] - d_cyc[j-1] != int'(vecs[v].rd) + 1) bad++;
      chk($sformatf("vec%0d_period", v), bad, 0);
      chk($sformatf("vec%0d_und_zero", v), n_undnz, 0);
    end

    // Two words back to back at full rate.
    restart(16'd0);
    wq.push_back(32'hFFFFFFFF);
    wq.push_back(32'h00000000);
    run_cycles(40);
    split();
    chk("b2b_count", d_i.size(), 32);
    bad = 0;
    for (int j = 0; j < d_i.size(); j++)
      if (d_i[j] != ((j < 16) ? NA : A) || d_q[j] != ((j < 16) ? NA : A)) bad++;
    chk("b2b_values", bad, 0);
    bad = 0;
    for (int j = 1; j < d_cyc.size(); j++)
      if (d_cyc[j] - d_cyc[j-1] != 1) bad++;
    chk("b2b_no_gap", bad, 0);
    chk("b2b_handshakes", hs_cnt, 2);
`endif

    // Single word then starvation.
    restart(16'd1);
    wq.push_back(32'h1B1B1B1B);
    run_cycles(44);
    split();
    chk("starve_count", d_i.size(), 16);
    bad = 0;
    for (int j = 0; j < d_b.size(); j++)
      if (d_b[j] != (j < 15)) bad++;
    chk("starve_busy", bad, 0);
    chk("starve_und_seen", (n_und >= 4), 1'b1);
    chk("starve_und_zero", n_undnz, 0);
    bad = 0;
    for (int j = 16; j < s_cyc.size(); j++)
      if (!s_u[j] || s_cyc[j] - s_cyc[j-1] != 2) bad++;
    chk("starve_und_period", bad, 0);

`ifndef QPSK_DIFF_ENC_EN
    // Abort after five symbols, then restart on a fresh word.
    restart(16'd1);
    wq.push_back(32'h12345678);
    d_i.delete();
    for (int k = 0; k < 40 && d_i.size() < 5; k++) begin
      run_cycles(1);
      split();
    end
    chk("abort_reach5", d_i.size(), 5);
    chk("abort_sym4_q", (d_q.size() >= 4) ? d_q[3] : 16'hxxxx, NA);
    chk("abort_sym5_i", (d_i.size() >= 5) ? d_i[4] : 16'hxxxx, A);
    enable = 1'b0;
    wq.delete();
    wq.push_back(32'hAAAAAAAA);
    s_valid = 1'b1;
    s_data = wq[0];
    #1;
    chk("abort_s_ready", s_ready, 1'b0);
    clr_log();
    run_cycles(1);
    chk("abort_i", i_out, Z);
    chk("abort_q", q_out, Z);
    chk("abort_sym_valid", sym_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    run_cycles(1);
    chk("abort_no_sym", s_cyc.size(), 0);
    clr_log();
    enable = 1'b1;
    run_cycles(12);
    split();
    chk("reen_hs", hs_cnt, 1);
    chk("reen_i0", (d_i.size() > 0) ? d_i[0] : 16'hxxxx, A);
    chk("reen_q0", (d_q.size() > 0) ? d_q[0] : 16'hxxxx, NA);
`else
    // Differential encoding of a constant 01 stream.
    restart(16'd1);
    wq.push_back(32'h55555555);
    run_cycles(40);
    split();
    chk("diff_count", (d_i.size() >= 8), 1'b1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("diff_i%0d", j), (j < d_i.size()) ? d_i[j] : 16'hxxxx,
          (j % 4 == 0 || j % 4 == 1) ? NA : A);
      chk($sformatf("diff_q%0d", j), (j < d_q.size()) ? d_q[j] : 16'hxxxx,
          (j % 4 == 0 || j % 4 == 3) ? A : NA);
    end
`endif

    // Asynchronous reset in the middle of a word.
    restart(16'd2);
    wq.push_back(32'h1B1B1B1B);
    d_i.delete();
    for (int k = 0; k < 40 && d_i.size() < 3; k++) begin
      run_cycles(1);
      split();
    end
    chk("arst_reach3", d_i.size(), 3);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("arst_i", i_out, Z);
    chk("arst_q", q_out, Z);
    chk("arst_sym_valid", sym_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_s_ready", s_ready, 1'b0);
    enable = 1'b0;
    wq.delete();
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    clr_log();
    run_cycles(10);
    chk("arst_quiet", s_cyc.size(), 0);
    enable = 1'b1;
    run_cycles(12);
    split();
    chk("arst_no_data", d_i.size(), 0);
    chk("arst_und_only", (n_und >= 3), 1'b1);
    chk("arst_und_zero", n_undnz, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
